req_arbiter4: RTL and testbench

- Upstream stage of the 4:2 encoder.
- Latches four independent request lines and picks one winner per round, round-robin by default.
- Presents the winner as a registered one-hot grant vector with a valid/ready handshake. The downstream encoder turns that vector into a 2-bit code.
- Includes a grant-timeout so a stalled consumer cannot starve the other requesters.

---
 rtl/req_arbiter4.sv | 191 +++++++++++++++++++
 tb/tb_req_arbiter4.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter4.sv
// ---------------------------------------------------------------------------
// req_arbiter4 -- four-channel request arbiter feeding the 4:2 encoder.
//
// Four level request lines are latched into a sticky pending register. One
// winner per round is offered downstream as a registered one-hot grant with
// a valid/ready handshake. An offer that is not taken within TIMEOUT cycles
// is withdrawn. Its pending bit is kept, so the stalled channel competes
// again later, but the other channels get their turn first.
//
// Optional feature (compile-time macro):
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, bit 3 highest, no pointer
//   ARB_FIXED_PRIO_EN  undefined -> round-robin from a rotating pointer
//
// Parameters:
//   TIMEOUT  cycles an offer may wait for gnt_ready (0 = never withdraw)
//   CNT_W    width of the offer-age counter (must hold TIMEOUT-1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_i      in   [3:0] level requests, sampled every clk
//   gnt_o      out  [3:0] registered one-hot grant, zero when not valid
//   gnt_valid  out  grant offer active
//   gnt_ready  in   consumer takes the grant when high with gnt_valid
//   pend_o     out  [3:0] pending-request register (debug view)
//   timeout_o  out  one-cycle pulse when an offer is withdrawn unaccepted
// ---------------------------------------------------------------------------
module req_arbiter4 #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic       gnt_valid,
  input  logic       gnt_ready,
  output logic [3:0] pend_o,
  output logic       timeout_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Last age value of an offer; only meaningful when the timeout is enabled.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               TO_EN    = (TIMEOUT > 0);

  state_t           state_r;
  logic [3:0]       pend_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       clr_s;
  logic [3:0]       pend_next_s;
  logic [1:0]       pick_s;
`ifndef ARB_FIXED_PRIO_EN
  logic [1:0]       ptr_r;
  logic [1:0]       win_r;
`endif

  // Index -> one-hot grant vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  // Highest set bit wins; the ascending scan lets higher bits overwrite.
  function automatic logic [1:0] fixed_pick(input logic [3:0] p);
    fixed_pick = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (p[i]) begin
        fixed_pick = 2'(i);
      end else begin
        fixed_pick = fixed_pick;
      end
    end
  endfunction
`else
  // First set bit scanning from ptr upward, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && p[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction
`endif

  // Winner of the pending set for the next offer.
  always_comb begin
    pick_s = 2'd0;
`ifdef ARB_FIXED_PRIO_EN
    pick_s = fixed_pick(pend_r);
`else
    pick_s = rr_pick(pend_r, ptr_r);
`endif
  end

  // Pending update: the accepted bit is cleared, new requests set (set wins).
  always_comb begin
    clr_s = 4'b0000;
    if ((state_r == OFFER) && gnt_ready) begin
      clr_s = gnt_o;
    end else begin
      clr_s = 4'b0000;
    end
    pend_next_s = (pend_r & ~clr_s) | req_i;
  end

  assign pend_o = pend_r;

  // Arbitration state machine with registered grant, valid and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pend_r    <= 4'b0000;
      cnt_r     <= '0;
      gnt_o     <= 4'b0000;
      gnt_valid <= 1'b0;
      timeout_o <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_r     <= 2'd0;
      win_r     <= 2'd0;
`endif
    end else begin
      pend_r    <= pend_next_s;
      timeout_o <= 1'b0;
      case (state_r)
        IDLE: begin
          // Decision uses the already-latched pend_r, giving one cycle of
          // latency from req_i and a bubble after each offer.
          if (pend_r != 4'b0000) begin
            gnt_o     <= onehot4(pick_s);
            gnt_valid <= 1'b1;
            cnt_r     <= '0;
            state_r   <= OFFER;
`ifndef ARB_FIXED_PRIO_EN
            win_r     <= pick_s;
`endif
          end else begin
            gnt_o     <= 4'b0000;
            gnt_valid <= 1'b0;
          end
        end
        OFFER: begin
          // Accept has precedence over a timeout on the same edge.
          if (gnt_ready) begin
            gnt_o     <= 4'b0000;
            gnt_valid <= 1'b0;
            state_r   <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
            ptr_r     <= win_r + 2'd1;
`endif
          end else if (TO_EN && (cnt_r == CNT_LAST)) begin
            gnt_o     <= 4'b0000;
            gnt_valid <= 1'b0;
            timeout_o <= 1'b1;
            state_r   <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
            ptr_r     <= win_r + 2'd1;
`endif
          end else begin
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CNT_ONE;
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          gnt_o     <= 4'b0000;
          gnt_valid <= 1'b0;
          cnt_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter4.sv
module tb_req_arbiter4;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       gnt_ready;
  logic [3:0] pend;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [3:0] m_pend;
  int         m_ptr;
  int         m_win;
  int         m_wait;
  bit         m_off;
  bit         m_to;

  req_arbiter4 #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .gnt_o     (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .pend_o    (pend),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] p, input int ptr);
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) if (p[k]) return k;
`else
    for (int k = 0; k < 4; k++) if (p[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = 4'b0000; m_ptr = 0; m_win = 0; m_wait = 0; m_off = 0; m_to = 0;
  endtask

  // One clock edge of the arbiter, from the rules: pick, hold, accept, timeout.
  task automatic model_edge(input logic [3:0] r, input logic rdy);
    logic [3:0] clr;
    clr = 4'b0000;
    m_to = 0;
    if (!m_off) begin
      if (m_pend != 4'b0000) begin
        m_win = pick(m_pend, m_ptr); m_off = 1; m_wait = 0;
      end
    end else if (rdy) begin
      clr[m_win] = 1'b1;
`ifndef ARB_FIXED_PRIO_EN
      m_ptr = (m_win + 1) % 4;
`endif
      m_off = 0;
    end else if (TO > 0 && m_wait == TO - 1) begin
      m_to = 1;
`ifndef ARB_FIXED_PRIO_EN
      m_ptr = (m_win + 1) % 4;
`endif
      m_off = 0;
    end else begin
      m_wait++;
    end
    m_pend = (m_pend & ~clr) | r;
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] eg;
    eg = m_off ? (4'b0001 << m_win) : 4'b0000;
    chk({tag, "_gnt"}, gnt, eg);
    chk({tag, "_valid"}, {3'b000, gnt_valid}, {3'b000, m_off});
    chk({tag, "_pend"}, pend, m_pend);
    chk({tag, "_timeout"}, {3'b000, timeout}, {3'b000, m_to});
    chk({tag, "_onehot"}, {3'b000, ($countones(gnt) <= 1)}, 4'b0001);
  endtask

  task automatic step(input string tag);
    logic [3:0] r;
    logic       rd;
    r  = req;
    rd = gnt_ready;
    @(posedge clk);
    model_edge(r, rd);
    #1;
    check_outputs(tag);
  endtask

  task automatic drain();
    req = 4'b0000; gnt_ready = 1'b1;
    for (int i = 0; i < 10; i++) step("drain");
  endtask

  initial begin
    logic [3:0] seen [$];
    logic [3:0] expg;
    int vcnt;
    int tcnt;

    // Reset state
    rst_n = 1'b0; req = 4'b0000; gnt_ready = 1'b0;
    model_reset();
    #2;
    check_outputs("reset");
    #10 rst_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 10; i++) step("idle");

    // All requesters, consumer always ready
    req = 4'b1111; gnt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("all4");
      if (gnt_valid) seen.push_back(gnt);
    end
    chk("all4_count", 4'(seen.size()), 4'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
      expg = 4'b1000;
`else
      expg = 4'b0001 << (i % 4);
`endif
      chk("all4_seq", seen[i], expg);
    end
    drain();

    // Single-cycle pulse on channel 2, consumer slow for 3 cycles
    gnt_ready = 1'b0; req = 4'b0100;
    step("pulse_latch");
    chk("pulse_pend", pend, 4'b0100);
    req = 4'b0000;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step("pulse_hold");
      if (gnt_valid && gnt == 4'b0100) vcnt++;
    end
    chk("pulse_stable", 4'(vcnt), 4'd4);
    gnt_ready = 1'b1;
    step("pulse_accept");
    chk("pulse_cleared", pend, 4'b0000);
    // Pointer now at 3: of {3,0} channel 3 wins first in round-robin
    req = 4'b1001;
    step("ptr_latch");
    req = 4'b0000;
    step("ptr_offer");
    chk("ptr_next3", gnt, 4'b1000);
    drain();

    // Timeout on channel 1
    gnt_ready = 1'b0; req = 4'b0010;
    step("to_latch");
    req = 4'b0000;
    vcnt = 0; tcnt = 0;
    for (int i = 0; i < 9; i++) begin
      step("to_wait");
      if (gnt_valid) vcnt++;
      if (timeout) tcnt++;
    end
    chk("to_valid_cycles", 4'(vcnt), 4'd8);
    chk("to_pulses", 4'(tcnt), 4'd1);
    chk("to_pend_kept", pend, 4'b0010);
    step("to_reoffer");
    chk("to_reoffer_gnt", gnt, 4'b0010);
    drain();

    // New request on the bit being accepted stays pending
    gnt_ready = 1'b0; req = 4'b0001;
    step("set_latch");
    req = 4'b0000;
    step("set_offer");
    gnt_ready = 1'b1; req = 4'b0001;
    step("set_accept");
    chk("set_wins", {3'b000, pend[0]}, 4'b0001);
    req = 4'b0000;
    step("set_reoffer");
    chk("set_reoffer_gnt", gnt, 4'b0001);
    drain();

    // Asynchronous reset in the middle of an offer of 1000
    gnt_ready = 1'b0; req = 4'b1000;
    step("rst_latch");
    req = 4'b0000;
    step("rst_offer");
    chk("rst_pre_gnt", gnt, 4'b1000);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    #2 rst_n = 1'b1;
    step("rst_after");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      gnt_ready = ($urandom_range(0, 4) != 0) ? (i % 64 < 40) : 1'b0;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
